// File: rtl/tx_seq_pkg.sv
// rtl/tx_seq_pkg.sv - shared state and mode definitions for the UART result sequencer
package tx_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } tx_seq_state_t;

  localparam logic MODE_VECTOR = 1'b0;
  localparam logic MODE_SCALAR = 1'b1;

endpackage

// File: rtl/tx_sequencer.sv
// rtl/tx_sequencer.sv - streams a vector result from memory, or a 16-bit scalar, to a UART one byte at a time
module tx_sequencer
  import tx_seq_pkg::*;
#(
  parameter int NBytes = 1024,
  parameter int ADDR_W = (NBytes > 1) ? $clog2(NBytes) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [15:0]       scalar_result,
  input  logic [7:0]        mem_data,
  input  logic              tx_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              send,
  output logic [7:0]        tx_byte,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_VEC = ADDR_W'(NBytes - 1);
  localparam logic [ADDR_W-1:0] LAST_SCL = ADDR_W'(1);

  tx_seq_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]        r_tx_byte, w_tx_byte_nxt;
  logic              r_mode, w_mode_nxt;
  logic [15:0]       r_scalar, w_scalar_nxt;
  logic [ADDR_W-1:0] w_last;

  assign w_last = (r_mode == MODE_SCALAR) ? LAST_SCL : LAST_VEC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tx_byte <= '0;
      r_mode    <= MODE_VECTOR;
      r_scalar  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tx_byte <= w_tx_byte_nxt;
      r_mode    <= w_mode_nxt;
      r_scalar  <= w_scalar_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tx_byte_nxt = r_tx_byte;
    w_mode_nxt    = r_mode;
    w_scalar_nxt  = r_scalar;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mode_nxt   = mode;
          w_scalar_nxt = scalar_result;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        // Scalar goes out high byte first
        if (r_mode == MODE_SCALAR)
          w_tx_byte_nxt = (r_cnt == '0) ? r_scalar[15:8] : r_scalar[7:0];
        else
          w_tx_byte_nxt = mem_data;
        w_state_nxt = S_SEND;
      end
      S_SEND: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_flag) begin
          if (r_cnt == w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr  = r_cnt;
  assign tx_byte   = r_tx_byte;
  assign mem_rd_en = (r_state == S_FETCH) && (r_mode == MODE_VECTOR);
  assign send      = (r_state == S_SEND);
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

endmodule
